// File: rtl/i2c_eeprom_slave.sv
// I2C responder modelling a byte-addressed EEPROM, with a write-mirror strobe port.
// Define I2C_SLV_AUTOINC_EN for page write / sequential read (pointer auto-increment).
module i2c_eeprom_slave #(
  parameter logic [6:0] DEVICE_ADDR = 7'b1010_011,
  parameter bit         ADDR_NUM    = 1'b1,
  parameter int         MEM_AW      = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              i2c_scl,
  inout  wire               i2c_sda,
  output logic              mem_wr_en,
  output logic [MEM_AW-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data,
  output logic              i2c_busy
);

`ifdef I2C_SLV_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_ACK_DA, S_ADDR_H, S_ACK_AH, S_ADDR_L, S_ACK_AL,
    S_WR_DATA, S_ACK_WR, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
  } state_t;

  // [0],[1] synchronise; [2] is the previous synchronised value for edge detection
  logic [2:0] scl_sync_q;
  logic [2:0] sda_sync_q;

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_done_q, byte_done_d;
  logic [7:0]        addr_h_q, addr_h_d;
  logic              rw_q, rw_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              wr_en_q, wr_en_d;
  logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic [7:0]        mem [2**MEM_AW];
  logic [7:0]        mem_rd_q;
  logic              mem_we;

  logic scl_rise, scl_fall, sda_rise, sda_fall, sda_in, scl_hi;
  logic start_det, stop_det;
  logic [MEM_AW-1:0] ptr_inc;
  logic [MEM_AW-1:0] ptr_load;

  assign scl_hi    = scl_sync_q[1];
  assign sda_in    = sda_sync_q[1];
  assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
  assign sda_rise  = sda_sync_q[1] & ~sda_sync_q[2];
  assign sda_fall  = ~sda_sync_q[1] & sda_sync_q[2];
  assign start_det = sda_fall & scl_hi;
  assign stop_det  = sda_rise & scl_hi;

  assign ptr_inc  = AUTOINC ? ptr_q + MEM_AW'(1) : ptr_q;
  assign ptr_load = ADDR_NUM ? MEM_AW'({addr_h_q, shift_q}) : MEM_AW'({8'h00, shift_q});

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done_d = byte_done_q;
    addr_h_d    = addr_h_q;
    rw_d        = rw_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;

    if (stop_det) begin
      state_d     = S_IDLE;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
    end else if (start_det) begin
      state_d     = S_DEV_ADDR;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b1;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
    end else begin
      case (state_q)
        S_DEV_ADDR, S_ADDR_H, S_ADDR_L, S_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_in};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            bit_cnt_d   = 3'd0;
            case (state_q)
              S_DEV_ADDR: begin
                if (shift_q[7:1] == DEVICE_ADDR) begin
                  rw_d     = shift_q[0];
                  sda_oe_d = 1'b1;
                  state_d  = S_ACK_DA;
                end else begin
                  state_d = S_WAIT_STOP;
                end
              end
              S_ADDR_H: begin
                addr_h_d = shift_q;
                sda_oe_d = 1'b1;
                state_d  = S_ACK_AH;
              end
              S_ADDR_L: begin
                ptr_d    = ptr_load;
                sda_oe_d = 1'b1;
                state_d  = S_ACK_AL;
              end
              default: begin
                // Commit the received byte on entry to the ACK slot
                mem_we    = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = shift_q;
                ptr_d     = ptr_inc;
                sda_oe_d  = 1'b1;
                state_d   = S_ACK_WR;
              end
            endcase
          end
        end
        S_ACK_DA: begin
          if (scl_fall) begin
            bit_cnt_d = 3'd0;
            if (rw_q) begin
              shift_d  = mem_rd_q;
              sda_oe_d = ~mem_rd_q[7];
              state_d  = S_RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ADDR_NUM ? S_ADDR_H : S_ADDR_L;
            end
          end
        end
        S_ACK_AH: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = S_ADDR_L;
          end
        end
        S_ACK_AL, S_ACK_WR: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = S_WR_DATA;
          end
        end
        S_RD_DATA: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = S_RD_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_in) state_d = S_WAIT_STOP;
            else        ptr_d   = ptr_inc;
          end else if (scl_fall) begin
            shift_d   = mem_rd_q;
            sda_oe_d  = ~mem_rd_q[7];
            bit_cnt_d = 3'd0;
            state_d   = S_RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      scl_sync_q  <= 3'b111;
      sda_sync_q  <= 3'b111;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      byte_done_q <= 1'b0;
      addr_h_q    <= 8'h00;
      rw_q        <= 1'b0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      scl_sync_q  <= {scl_sync_q[1:0], i2c_scl};
      sda_sync_q  <= {sda_sync_q[1:0], i2c_sda};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
      addr_h_q    <= addr_h_d;
      rw_q        <= rw_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Byte store: not reset, registered read of the current pointer
  always_ff @(posedge sys_clk) begin
    if (mem_we && sys_rst_n) mem[ptr_q] <= shift_q;
    mem_rd_q <= mem[ptr_q];
  end

  // Release the bus immediately while reset is held
  assign i2c_sda     = (sda_oe_q && sys_rst_n) ? 1'b0 : 1'bz;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign i2c_busy    = busy_q;

endmodule
